multi_account_bank: RTL and testbench



---
 rtl/multi_account_bank_pkg.sv | 48 ++++
 rtl/multi_account_bank_balance_store.sv | 49 ++++
 rtl/multi_account_bank.sv | 175 +++++++++++++++++
 tb/tb_multi_account_bank.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_account_bank_pkg.sv
// rtl/multi_account_bank_pkg.sv - opcodes, status codes, FSM states and log layout for the bank
package multi_account_bank_pkg;

    // Request opcodes; any value above OP_DEPOSIT is illegal
    localparam logic [2:0] OP_BALANCE  = 3'b000;
    localparam logic [2:0] OP_WITHDRAW = 3'b001;
    localparam logic [2:0] OP_TRANSFER = 3'b010;
    localparam logic [2:0] OP_DEPOSIT  = 3'b011;

    // Response status codes
    localparam logic [2:0] ST_OK           = 3'd0;
    localparam logic [2:0] ST_INSUFFICIENT = 3'd1;
    localparam logic [2:0] ST_BAD_ID       = 3'd2;
    localparam logic [2:0] ST_BAD_OP       = 3'd3;
    localparam logic [2:0] ST_OVERFLOW     = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_CREDIT,
        S_RESP
    } state_e;

    // Log word field positions (LSB of each field)
    localparam int LOG_OP_LSB     = 29;
    localparam int LOG_STATUS_LSB = 26;
    localparam int LOG_SRC_LSB    = 18;
    localparam int LOG_DST_LSB    = 10;
    localparam int LOG_CNT_LSB    = 0;

    function automatic logic [31:0] make_log(
        input logic [2:0] op,
        input logic [2:0] status,
        input logic [7:0] src,
        input logic [7:0] dst,
        input logic [9:0] cnt
    );
        logic [31:0] w;
        w = '0;
        w[LOG_OP_LSB     +: 3]  = op;
        w[LOG_STATUS_LSB +: 3]  = status;
        w[LOG_SRC_LSB    +: 8]  = src;
        w[LOG_DST_LSB    +: 8]  = dst;
        w[LOG_CNT_LSB    +: 10] = cnt;
        return w;
    endfunction

endpackage

// File: rtl/multi_account_bank_balance_store.sv
// rtl/multi_account_bank_balance_store.sv - per-account balance flops, two read ports, one write port
module bank_balance_store
    import multi_account_bank_pkg::*;
#(
    parameter int NUM_ACCOUNTS = 16,
    parameter int ID_W         = 8,
    parameter int AMT_W        = 32,
    parameter logic [AMT_W-1:0] INIT_BALANCE = AMT_W'(100000)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [ID_W-1:0]  src_id,
    input  logic [ID_W-1:0]  dst_id,
    output logic [AMT_W-1:0] src_bal,
    output logic [AMT_W-1:0] dst_bal,
    input  logic             wr_en,
    input  logic [ID_W-1:0]  wr_id,
    input  logic [AMT_W-1:0] wr_data
);

    localparam int IDX_W = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1;
    localparam logic [ID_W:0] NUM_ACC = (ID_W+1)'(NUM_ACCOUNTS);

    logic [AMT_W-1:0] bal [NUM_ACCOUNTS];

    logic src_ok;
    logic dst_ok;
    logic wr_ok;

    assign src_ok = {1'b0, src_id} < NUM_ACC;
    assign dst_ok = {1'b0, dst_id} < NUM_ACC;
    assign wr_ok  = {1'b0, wr_id}  < NUM_ACC;

    // Out-of-range IDs read as zero so the array is never indexed past its end
    assign src_bal = src_ok ? bal[src_id[IDX_W-1:0]] : '0;
    assign dst_bal = dst_ok ? bal[dst_id[IDX_W-1:0]] : '0;

    // Balance array: reset reloads every account, otherwise one write per cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                bal[i] <= INIT_BALANCE;
            end
        end else if (wr_en && wr_ok) begin
            bal[wr_id[IDX_W-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/multi_account_bank.sv
// rtl/multi_account_bank.sv - multi-account bank: validate, debit/credit, respond and log
module multi_account_bank
    import multi_account_bank_pkg::*;
#(
    parameter int NUM_ACCOUNTS = 16,
    parameter int ID_W         = 8,
    parameter int AMT_W        = 32,
    parameter logic [AMT_W-1:0] INIT_BALANCE = AMT_W'(100000)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [ID_W-1:0]  req_src_id,
    input  logic [ID_W-1:0]  req_dst_id,
    input  logic [AMT_W-1:0] req_amount,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2:0]       rsp_status,
    output logic [ID_W-1:0]  rsp_account_id,
    output logic [AMT_W-1:0] rsp_balance,
    output logic [31:0]      txn_log,
    output logic [31:0]      txn_count
);

    localparam logic [ID_W:0] NUM_ACC = (ID_W+1)'(NUM_ACCOUNTS);

    state_e           state;
    logic [2:0]       op_q;
    logic [ID_W-1:0]  src_q;
    logic [ID_W-1:0]  dst_q;
    logic [AMT_W-1:0] amt_q;

    logic [AMT_W-1:0] src_bal;
    logic [AMT_W-1:0] dst_bal;
    logic             wr_en;
    logic [ID_W-1:0]  wr_id;
    logic [AMT_W-1:0] wr_data;

    logic             src_ok;
    logic             dst_ok;
    logic             xfer_move;
    logic [AMT_W:0]   src_sum;
    logic [AMT_W:0]   dst_sum;
    logic [2:0]       chk_status;
    logic [AMT_W-1:0] src_new;
    logic [31:0]      cnt_next;

    bank_balance_store #(
        .NUM_ACCOUNTS (NUM_ACCOUNTS),
        .ID_W         (ID_W),
        .AMT_W        (AMT_W),
        .INIT_BALANCE (INIT_BALANCE)
    ) u_store (
        .clk     (clk),
        .reset_n (reset_n),
        .src_id  (src_q),
        .dst_id  (dst_q),
        .src_bal (src_bal),
        .dst_bal (dst_bal),
        .wr_en   (wr_en),
        .wr_id   (wr_id),
        .wr_data (wr_data)
    );

    assign req_ready = (state == S_IDLE);

    assign src_ok    = {1'b0, src_q} < NUM_ACC;
    assign dst_ok    = {1'b0, dst_q} < NUM_ACC;
    assign xfer_move = (op_q == OP_TRANSFER) && (src_q != dst_q);
    assign src_sum   = {1'b0, src_bal} + {1'b0, amt_q};
    assign dst_sum   = {1'b0, dst_bal} + {1'b0, amt_q};
    assign cnt_next  = txn_count + 32'd1;

    // Validation in priority order; every check sees balances before any write
    always_comb begin
        chk_status = ST_OK;
        if (op_q > OP_DEPOSIT) begin
            chk_status = ST_BAD_OP;
        end else if (!src_ok || (op_q == OP_TRANSFER && !dst_ok)) begin
            chk_status = ST_BAD_ID;
        end else if ((op_q == OP_WITHDRAW || op_q == OP_TRANSFER) && (amt_q > src_bal)) begin
            chk_status = ST_INSUFFICIENT;
        end else if ((op_q == OP_DEPOSIT && src_sum[AMT_W]) || (xfer_move && dst_sum[AMT_W])) begin
            chk_status = ST_OVERFLOW;
        end
    end

    // Source balance after a successful operation; self-transfer leaves it alone
    always_comb begin
        src_new = src_bal;
        if (op_q == OP_WITHDRAW || xfer_move) begin
            src_new = src_bal - amt_q;
        end else if (op_q == OP_DEPOSIT) begin
            src_new = src_sum[AMT_W-1:0];
        end
    end

    // Store write port: source update in CHECK, destination credit in CREDIT
    always_comb begin
        wr_en   = 1'b0;
        wr_id   = src_q;
        wr_data = src_new;
        if (state == S_CHECK && chk_status == ST_OK &&
            (op_q == OP_WITHDRAW || op_q == OP_DEPOSIT || xfer_move)) begin
            wr_en = 1'b1;
        end else if (state == S_CREDIT) begin
            wr_en   = 1'b1;
            wr_id   = dst_q;
            wr_data = dst_sum[AMT_W-1:0];
        end
    end

    // Control FSM with registered response, log and counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            op_q           <= '0;
            src_q          <= '0;
            dst_q          <= '0;
            amt_q          <= '0;
            rsp_valid      <= 1'b0;
            rsp_status     <= '0;
            rsp_account_id <= '0;
            rsp_balance    <= '0;
            txn_log        <= '0;
            txn_count      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q  <= req_op;
                        src_q <= req_src_id;
                        dst_q <= req_dst_id;
                        amt_q <= req_amount;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (chk_status == ST_OK && xfer_move) begin
                        state <= S_CREDIT;
                    end else begin
                        rsp_valid      <= 1'b1;
                        rsp_status     <= chk_status;
                        rsp_account_id <= src_q;
                        rsp_balance    <= (chk_status == ST_OK) ? src_new : src_bal;
                        txn_count      <= cnt_next;
                        txn_log        <= make_log(op_q, chk_status, 8'(src_q), 8'(dst_q),
                                                   cnt_next[9:0]);
                        state          <= S_RESP;
                    end
                end
                S_CREDIT: begin
                    // Source was debited last cycle, so the read port already shows the new value
                    rsp_valid      <= 1'b1;
                    rsp_status     <= ST_OK;
                    rsp_account_id <= src_q;
                    rsp_balance    <= src_bal;
                    txn_count      <= cnt_next;
                    txn_log        <= make_log(op_q, ST_OK, 8'(src_q), 8'(dst_q), cnt_next[9:0]);
                    state          <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_account_bank.sv
// tb/tb_multi_account_bank.sv - directed bench with a behavioural account model
module tb_multi_account_bank;

    localparam int N = 16;
    localparam longint unsigned MAXV = 64'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [7:0]  req_src_id;
    logic [7:0]  req_dst_id;
    logic [31:0] req_amount;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_status;
    logic [7:0]  rsp_account_id;
    logic [31:0] rsp_balance;
    logic [31:0] txn_log;
    logic [31:0] txn_count;

    int total = 0;
    int bad = 0;

    longint unsigned mbal [N];
    int unsigned     mcnt;

    logic [2:0]  e_status;
    logic [31:0] e_bal;
    bit          e_bal_care;
    logic [7:0]  e_id;
    logic [31:0] e_log;
    logic [31:0] e_cnt;
    int          e_lat;
    bit          exp_pending = 1'b0;

    logic [2:0]  got_status;
    logic [31:0] got_bal;
    logic [31:0] got_log;
    logic [31:0] got_cnt;
    int          got_lat;

    multi_account_bank dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_src_id     (req_src_id),
        .req_dst_id     (req_dst_id),
        .req_amount     (req_amount),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_status     (rsp_status),
        .rsp_account_id (rsp_account_id),
        .rsp_balance    (rsp_balance),
        .txn_log        (txn_log),
        .txn_count      (txn_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mbal[i] = 100000;
        mcnt = 0;
    endtask

    // Apply one request to the account model and record what the response must be
    task automatic model_exec(input logic [2:0] op, input int src, input int dst,
                              input longint unsigned amt);
        longint unsigned sb, db;
        bit sv, dv;
        logic [2:0] st;
        sv = (src < N);
        dv = (dst < N);
        sb = sv ? mbal[src] : 0;
        db = dv ? mbal[dst] : 0;
        e_lat = 2;
        if (op > 3) st = 3;
        else if (!sv || (op == 2 && !dv)) st = 2;
        else if ((op == 1 || op == 2) && amt > sb) st = 1;
        else if ((op == 3 && sb + amt > MAXV) || (op == 2 && src != dst && db + amt > MAXV)) st = 4;
        else begin
            st = 0;
            if (op == 1) mbal[src] = sb - amt;
            else if (op == 3) mbal[src] = sb + amt;
            else if (op == 2 && src != dst) begin
                mbal[src] = sb - amt;
                mbal[dst] = db + amt;
                e_lat = 3;
            end
        end
        mcnt++;
        e_status   = st;
        e_bal_care = sv;
        e_bal      = sv ? 32'(mbal[src]) : 32'd0;
        e_id       = 8'(src);
        e_cnt      = mcnt;
        e_log      = {op, st, 8'(src), 8'(dst), mcnt[9:0]};
    endtask

    // Every cycle a response is held, it must match the model and hold req_ready low
    always @(negedge clk) begin
        if (reset_n && exp_pending && rsp_valid) begin
            chk("rsp_status", rsp_status, e_status);
            chk("rsp_account_id", rsp_account_id, e_id);
            if (e_bal_care) chk("rsp_balance", rsp_balance, e_bal);
            chk("txn_log", txn_log, e_log);
            chk("txn_count", txn_count, e_cnt);
            chk("req_ready_in_resp", req_ready, 0);
        end
    end

    task automatic do_req(input logic [2:0] op, input logic [7:0] src, input logic [7:0] dst,
                          input logic [31:0] amt, input int hold);
        int edges;
        @(negedge clk);
        req_valid  = 1'b1;
        req_op     = op;
        req_src_id = src;
        req_dst_id = dst;
        req_amount = amt;
        chk("req_ready_idle", req_ready, 1);
        model_exec(op, int'(src), int'(dst), longint'(amt));
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_op     = 3'b110;
        req_src_id = 8'hAA;
        req_dst_id = 8'h55;
        req_amount = 32'hDEAD_BEEF;
        exp_pending = 1'b1;
        edges = 1;
        while (!rsp_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk("rsp_valid_rise", rsp_valid, 1);
        chk("latency", edges, e_lat);
        got_status = rsp_status;
        got_bal    = rsp_balance;
        got_log    = txn_log;
        got_cnt    = txn_count;
        got_lat    = edges;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready   = 1'b0;
        exp_pending = 1'b0;
        chk("rsp_valid_drop", rsp_valid, 0);
        chk("req_ready_back", req_ready, 1);
    endtask

    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        rsp_ready  = 1'b0;
        req_op     = '0;
        req_src_id = '0;
        req_dst_id = '0;
        req_amount = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_status", rsp_status, 0);
        chk("rst_rsp_account_id", rsp_account_id, 0);
        chk("rst_rsp_balance", rsp_balance, 0);
        chk("rst_txn_log", txn_log, 0);
        chk("rst_txn_count", txn_count, 0);
        @(negedge clk);
        reset_n = 1'b1;

        do_req(3'b000, 8'd0, 8'd0, 32'd0, 0);
        chk("lit1_status", got_status, 0);
        chk("lit1_bal", got_bal, 100000);
        chk("lit1_lat", got_lat, 2);
        chk("lit1_cnt", got_cnt, 1);

        do_req(3'b001, 8'd0, 8'd0, 32'd20000, 0);
        chk("lit2_bal", got_bal, 80000);

        do_req(3'b001, 8'd0, 8'd0, 32'd90000, 0);
        chk("lit3_status", got_status, 1);
        chk("lit3_bal", got_bal, 80000);
        chk("lit3_log", got_log, 32'h2400_0003);

        do_req(3'b010, 8'd0, 8'd5, 32'd30000, 0);
        chk("lit4_status", got_status, 0);
        chk("lit4_bal", got_bal, 50000);
        chk("lit4_lat", got_lat, 3);
        chk("lit4_log", got_log, 32'h4000_1404);

        do_req(3'b000, 8'd5, 8'd0, 32'd0, 0);
        chk("lit5_bal", got_bal, 130000);

        do_req(3'b010, 8'd5, 8'd5, 32'd1000, 0);
        chk("lit6_status", got_status, 0);
        chk("lit6_bal", got_bal, 130000);
        chk("lit6_lat", got_lat, 2);

        do_req(3'b000, 8'd16, 8'd0, 32'd0, 0);
        chk("lit7_status", got_status, 2);

        do_req(3'b111, 8'd0, 8'd0, 32'd5, 0);
        chk("lit8_status", got_status, 3);

        do_req(3'b011, 8'd1, 8'd0, 32'hFFFF_FFFF, 0);
        chk("lit9_status", got_status, 4);
        chk("lit9_bal", got_bal, 100000);
        chk("lit9_cnt", got_cnt, 9);

        do_req(3'b001, 8'd2, 8'd0, 32'd100000, 0);
        chk("lit10_bal", got_bal, 0);
        do_req(3'b011, 8'd2, 8'd0, 32'd0, 0);
        chk("lit11_status", got_status, 0);
        do_req(3'b010, 8'd0, 8'd20, 32'd10, 0);
        chk("lit12_status", got_status, 2);
        do_req(3'b011, 8'd4, 8'd0, 32'd4294867295, 0);
        chk("lit13_bal", got_bal, 32'hFFFF_FFFF);
        do_req(3'b010, 8'd1, 8'd4, 32'd1, 0);
        chk("lit14_status", got_status, 4);
        chk("lit14_bal", got_bal, 100000);
        do_req(3'b010, 8'd3, 8'd6, 32'd100001, 0);
        chk("lit15_status", got_status, 1);

        do_req(3'b000, 8'd5, 8'd0, 32'd0, 5);
        chk("lit16_bal", got_bal, 130000);

        // Abort a transfer 0->3 while it is in its credit cycle
        @(negedge clk);
        req_valid  = 1'b1;
        req_op     = 3'b010;
        req_src_id = 8'd0;
        req_dst_id = 8'd3;
        req_amount = 32'd1234;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_req_ready", req_ready, 0);
        chk("mid_rsp_valid", rsp_valid, 0);
        reset_n = 1'b0;
        #1;
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_txn_count", txn_count, 0);
        chk("abort_txn_log", txn_log, 0);
        chk("abort_req_ready", req_ready, 1);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        do_req(3'b000, 8'd0, 8'd0, 32'd0, 0);
        chk("post_bal0", got_bal, 100000);
        chk("post_cnt", got_cnt, 1);
        do_req(3'b000, 8'd3, 8'd0, 32'd0, 0);
        chk("post_bal3", got_bal, 100000);
        do_req(3'b000, 8'd5, 8'd0, 32'd0, 0);
        chk("post_bal5", got_bal, 100000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
